// File: rtl/signal_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/signal_debouncer_sync_2ff.sv
// Two-flop level synchronizer for asynchronous single-bit inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule : sync_2ff

// File: rtl/signal_debouncer.sv
// Debounces a raw switch level: y follows the synchronized input only after
// it has differed from y for STABLE_CYCLES consecutive cycles.
module signal_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    output logic y,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 1024) begin : g_bad_stable_cycles
        $error("signal_debouncer: STABLE_CYCLES must be in 1..1024");
    end

    logic             s2;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a_raw),
        .q     (s2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any agreement between s2 and y drops back to IDLE and discards progress.
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        y_d     = y_q;
        if (s2 != y_q) begin
            if (cnt_q == CNT_LAST) begin
                y_d = s2;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = COUNT;
            end
        end
        // Edge pulses are registered alongside y, so they appear with the new y.
        rise_d = y_d & ~y_q;
        fall_d = ~y_d & y_q;
    end

    assign y    = y_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == COUNT);

endmodule : signal_debouncer
